// File: rtl/dvs_cdma_v2.sv
// DVS event extractor: compares a windowed camera stream against a per-line reference
// fetched from BRAM, emits packed 2-bit ON/OFF codes and writes back the updated reference.
module dvs_cdma_v2 #(
   parameter int PIX_W   = 8,
   parameter int DATA_W  = 32,
   parameter int FRAME_W = 320,
   parameter int FRAME_H = 240,
   parameter int WIN_X0  = 96,
   parameter int WIN_Y0  = 56,
   parameter int WIN_W   = 128,
   parameter int WIN_H   = 128,
   parameter int ADDR_W  = 17
) (
   input  logic                  pclk,
   input  logic                  reset,
   input  logic                  vsync,
   input  logic                  href,
   input  logic                  pix_valid,
   input  logic [PIX_W-1:0]      pix_data,
   input  logic [PIX_W-1:0]      threshold,
   input  logic                  capture,
   output logic                  new_frame,
   output logic                  read_new_line,
   output logic                  write_new_line,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [DATA_W-1:0]     rd_data,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [DATA_W-1:0]     wr_data,
   output logic [DATA_W/8-1:0]   wr_we,
   output logic [ADDR_W-1:0]     ev_addr,
   output logic [DATA_W-1:0]     ev_data,
   output logic [DATA_W/8-1:0]   ev_we,
   output logic [15:0]           ev_count,
   output logic                  line_short
);

   localparam int PPW = DATA_W / PIX_W;
   localparam int EPW = DATA_W / 2;
   localparam int BW  = DATA_W / 8;

   localparam logic [15:0] X0_C  = 16'(WIN_X0);
   localparam logic [15:0] X1_C  = 16'(WIN_X0 + WIN_W);
   localparam logic [15:0] XL_C  = 16'(WIN_X0 + WIN_W - 1);
   localparam logic [15:0] Y0_C  = 16'(WIN_Y0);
   localparam logic [15:0] Y1_C  = 16'(WIN_Y0 + WIN_H);
   localparam logic [15:0] FW_C  = 16'(FRAME_W);
   localparam logic [15:0] PPW_C = 16'(PPW);
   localparam logic [15:0] EPW_C = 16'(EPW);
   localparam logic [15:0] PIX_C = 16'(PIX_W);
   localparam logic [DATA_W-1:0] PMASK_C = DATA_W'({PIX_W{1'b1}});

   generate
      if ((WIN_W % EPW) != 0) begin : g_bad_win_w
         $error("WIN_W must be a multiple of DATA_W/2");
      end
   endgenerate

   logic                vsync_q, href_q, armed_q, capture_q;
   logic                armed_d, capture_d;
   logic [15:0]         col_q, col_d, row_q, row_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d, ev_count_q, ev_count_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, ev_addr_q, ev_addr_d;
   logic [DATA_W-1:0]   ref_acc_q, ref_acc_d, ev_acc_q, ev_acc_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d, ev_data_q, ev_data_d;
   logic [BW-1:0]       wr_we_q, wr_we_d, ev_we_q, ev_we_d;
   logic                ref_pend_q, ref_pend_d, ev_pend_q, ev_pend_d;
   logic                final_q, final_d, wnl_q, wnl_d, rnl_q, rnl_d, nf_q, nf_d;
   logic                line_short_q, line_short_d;

   logic                vsync_fall_s, vsync_rise_s, href_fall_s, href_rise_s;
   logic                win_row_s, next_win_s, take_s;
   logic [15:0]         off_s, rslot_s, eslot_s, rword_s, eword_s, sh_s, esh_s;
   logic [DATA_W-1:0]   ref_base_s, ev_base_s;
   logic [PIX_W-1:0]    ref_pix_s, new_ref_s;
   logic signed [PIX_W:0] diff_s, thr_s, nthr_s;
   logic [1:0]          code_s;

   assign vsync_fall_s = vsync_q & ~vsync;
   assign vsync_rise_s = ~vsync_q & vsync;
   assign href_fall_s  = href_q & ~href;
   assign href_rise_s  = ~href_q & href;
   assign win_row_s    = (row_q >= Y0_C) && (row_q < Y1_C);
   assign next_win_s   = ((row_q + 16'd1) >= Y0_C) && ((row_q + 16'd1) < Y1_C);
   assign take_s       = armed_q & href & pix_valid & win_row_s &
                         (col_q >= X0_C) & (col_q < X1_C) & (col_q < FW_C);

   // Slot 0 of a word takes the freshly fetched BRAM word; later slots read the held copy.
   assign off_s      = col_q - X0_C;
   assign rslot_s    = off_s % PPW_C;
   assign eslot_s    = off_s % EPW_C;
   assign rword_s    = off_s / PPW_C;
   assign eword_s    = off_s / EPW_C;
   assign sh_s       = rslot_s * PIX_C;
   assign esh_s      = eslot_s * 16'd2;
   assign ref_base_s = (rslot_s == 16'd0) ? rd_data : ref_acc_q;
   assign ev_base_s  = (eslot_s == 16'd0) ? {DATA_W{1'b0}} : ev_acc_q;
   assign ref_pix_s  = PIX_W'(ref_base_s >> sh_s);
   assign diff_s     = $signed({1'b0, pix_data}) - $signed({1'b0, ref_pix_s});
   assign thr_s      = $signed({1'b0, threshold});
   assign nthr_s     = -thr_s;

   // Event classification; strict comparisons so diff equal to threshold is silent.
   always_comb begin
      code_s    = 2'b00;
      new_ref_s = ref_pix_s;
      if (capture_q) begin
         code_s    = 2'b00;
         new_ref_s = pix_data;
      end else if (diff_s > thr_s) begin
         code_s    = 2'b01;
         new_ref_s = pix_data;
      end else if (diff_s < nthr_s) begin
         code_s    = 2'b10;
         new_ref_s = pix_data;
      end else begin
         code_s    = 2'b00;
         new_ref_s = ref_pix_s;
      end
   end

   // Next-state logic for counters, word assembly, write ports and pulses.
   always_comb begin
      armed_d      = armed_q;
      capture_d    = capture_q;
      col_d        = col_q;
      row_d        = row_q;
      frame_cnt_d  = frame_cnt_q;
      ev_count_d   = ev_count_q;
      rd_addr_d    = rd_addr_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      ev_addr_d    = ev_addr_q;
      ev_data_d    = ev_data_q;
      ref_acc_d    = ref_acc_q;
      ev_acc_d     = ev_acc_q;
      ref_pend_d   = ref_pend_q;
      ev_pend_d    = ev_pend_q;
      line_short_d = line_short_q;
      wr_we_d      = {BW{1'b0}};
      ev_we_d      = {BW{1'b0}};
      final_d      = 1'b0;
      wnl_d        = final_q;
      nf_d         = vsync_fall_s;
      rnl_d        = (armed_q & href_fall_s & next_win_s) | (vsync_fall_s & (Y0_C == 16'd0));

      if (!href) begin
         col_d = 16'd0;
      end else if (pix_valid && (col_q != 16'hFFFF)) begin
         col_d = col_q + 16'd1;
      end else begin
         col_d = col_q;
      end

      if (vsync) begin
         row_d = 16'd0;
      end else if (href_fall_s) begin
         row_d = row_q + 16'd1;
      end else begin
         row_d = row_q;
      end

      if (vsync_fall_s) begin
         armed_d   = 1'b1;
         capture_d = capture;
      end else begin
         armed_d   = armed_q;
         capture_d = capture_q;
      end

      if (armed_q && href_rise_s && win_row_s) begin
         rd_addr_d = {ADDR_W{1'b0}};
      end else if (take_s && (rslot_s == 16'd0)) begin
         rd_addr_d = ADDR_W'(rword_s + 16'd1);
      end else begin
         rd_addr_d = rd_addr_q;
      end

      if (take_s) begin
         ref_acc_d  = (ref_base_s & ~(PMASK_C << sh_s)) | (DATA_W'(new_ref_s) << sh_s);
         ev_acc_d   = ev_base_s | (DATA_W'(code_s) << esh_s);
         ref_pend_d = (rslot_s != PPW_C - 16'd1);
         ev_pend_d  = (eslot_s != EPW_C - 16'd1);
         final_d    = (col_q == XL_C);
         if (rslot_s == PPW_C - 16'd1) begin
            wr_addr_d = ADDR_W'(rword_s);
            wr_data_d = ref_acc_d;
            wr_we_d   = {BW{1'b1}};
         end else begin
            wr_we_d   = {BW{1'b0}};
         end
         if (eslot_s == EPW_C - 16'd1) begin
            ev_addr_d = ADDR_W'(eword_s);
            ev_data_d = ev_acc_d;
            ev_we_d   = {BW{1'b1}};
         end else begin
            ev_we_d   = {BW{1'b0}};
         end
         if ((code_s != 2'b00) && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
         end else begin
            frame_cnt_d = frame_cnt_q;
         end
      end else if (armed_q && href_fall_s && win_row_s && (col_q < X1_C)) begin
         // Early line end: push out half-built words; untouched slots still hold reference/00.
         line_short_d = 1'b1;
         final_d      = 1'b1;
         ref_pend_d   = 1'b0;
         ev_pend_d    = 1'b0;
         if (ref_pend_q) begin
            wr_addr_d = ADDR_W'(rword_s);
            wr_data_d = ref_acc_q;
            wr_we_d   = {BW{1'b1}};
         end else begin
            wr_we_d   = {BW{1'b0}};
         end
         if (ev_pend_q) begin
            ev_addr_d = ADDR_W'(eword_s);
            ev_data_d = ev_acc_q;
            ev_we_d   = {BW{1'b1}};
         end else begin
            ev_we_d   = {BW{1'b0}};
         end
      end else begin
         final_d = 1'b0;
      end

      if (armed_q && vsync_rise_s) begin
         ev_count_d  = frame_cnt_q;
         frame_cnt_d = 16'd0;
      end else begin
         ev_count_d  = ev_count_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge pclk) begin
      if (reset) begin
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         armed_q      <= 1'b0;
         capture_q    <= 1'b0;
         col_q        <= 16'd0;
         row_q        <= 16'd0;
         frame_cnt_q  <= 16'd0;
         ev_count_q   <= 16'd0;
         rd_addr_q    <= {ADDR_W{1'b0}};
         wr_addr_q    <= {ADDR_W{1'b0}};
         ev_addr_q    <= {ADDR_W{1'b0}};
         wr_data_q    <= {DATA_W{1'b0}};
         ev_data_q    <= {DATA_W{1'b0}};
         ref_acc_q    <= {DATA_W{1'b0}};
         ev_acc_q     <= {DATA_W{1'b0}};
         wr_we_q      <= {BW{1'b0}};
         ev_we_q      <= {BW{1'b0}};
         ref_pend_q   <= 1'b0;
         ev_pend_q    <= 1'b0;
         final_q      <= 1'b0;
         wnl_q        <= 1'b0;
         rnl_q        <= 1'b0;
         nf_q         <= 1'b0;
         line_short_q <= 1'b0;
      end else begin
         vsync_q      <= vsync;
         href_q       <= href;
         armed_q      <= armed_d;
         capture_q    <= capture_d;
         col_q        <= col_d;
         row_q        <= row_d;
         frame_cnt_q  <= frame_cnt_d;
         ev_count_q   <= ev_count_d;
         rd_addr_q    <= rd_addr_d;
         wr_addr_q    <= wr_addr_d;
         ev_addr_q    <= ev_addr_d;
         wr_data_q    <= wr_data_d;
         ev_data_q    <= ev_data_d;
         ref_acc_q    <= ref_acc_d;
         ev_acc_q     <= ev_acc_d;
         wr_we_q      <= wr_we_d;
         ev_we_q      <= ev_we_d;
         ref_pend_q   <= ref_pend_d;
         ev_pend_q    <= ev_pend_d;
         final_q      <= final_d;
         wnl_q        <= wnl_d;
         rnl_q        <= rnl_d;
         nf_q         <= nf_d;
         line_short_q <= line_short_d;
      end
   end

   assign new_frame      = nf_q;
   assign read_new_line  = rnl_q;
   assign write_new_line = wnl_q;
   assign rd_addr        = rd_addr_q;
   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;
   assign wr_we          = wr_we_q;
   assign ev_addr        = ev_addr_q;
   assign ev_data        = ev_data_q;
   assign ev_we          = ev_we_q;
   assign ev_count       = ev_count_q;
   assign line_short     = line_short_q;

endmodule

// File: tb/tb_dvs_cdma_v2.sv
// Directed bench for dvs_cdma_v2: drives synthetic frames against a one-line reference BRAM model.
module tb_dvs_cdma_v2;

   localparam int WIN_Y0 = 56;

   logic        pclk = 1'b0;
   logic        reset, vsync, href, pix_valid, capture;
   logic [7:0]  pix_data, threshold;
   logic [31:0] rd_data = 32'h0;
   logic        new_frame, read_new_line, write_new_line, line_short;
   logic [16:0] rd_addr, wr_addr, ev_addr;
   logic [31:0] wr_data, ev_data;
   logic [3:0]  wr_we, ev_we;
   logic [15:0] ev_count;

   logic [31:0] ref_mem [0:63];

   int n_tests = 0;
   int n_fail  = 0;

   int wr_cnt = 0, ev_cnt = 0, wr_bad = 0, ev_bad = 0, we_bad = 0;
   int wnl_cnt = 0, wnl_bad = 0, rnl_cnt = 0, nf_cnt = 0;
   logic [31:0] exp_wr = 32'h0, exp_ev = 32'h0, last_wr = 32'h0, last_ev = 32'h0;
   logic [16:0] last_wr_addr = 17'h0, last_ev_addr = 17'h0;
   logic        prev_write = 1'b0;

   dvs_cdma_v2 dut (
      .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .pix_valid(pix_valid),
      .pix_data(pix_data), .threshold(threshold), .capture(capture),
      .new_frame(new_frame), .read_new_line(read_new_line), .write_new_line(write_new_line),
      .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_we(wr_we), .ev_addr(ev_addr), .ev_data(ev_data), .ev_we(ev_we),
      .ev_count(ev_count), .line_short(line_short)
   );

   always #5 pclk = ~pclk;

   // Reference BRAM with one cycle read latency.
   always @(posedge pclk) rd_data <= ref_mem[rd_addr[5:0]];

   // Write-port monitor, sampled on the falling edge.
   always @(negedge pclk) begin
      if (wr_we != 4'h0) begin
         wr_cnt++;
         last_wr = wr_data;
         last_wr_addr = wr_addr;
         if (wr_data !== exp_wr) wr_bad++;
         if (wr_we !== 4'hF) we_bad++;
      end
      if (ev_we != 4'h0) begin
         ev_cnt++;
         last_ev = ev_data;
         last_ev_addr = ev_addr;
         if (ev_data !== exp_ev) ev_bad++;
         if (ev_we !== 4'hF) we_bad++;
      end
      if (write_new_line) begin
         wnl_cnt++;
         if (!prev_write) wnl_bad++;
      end
      if (read_new_line) rnl_cnt++;
      if (new_frame) nf_cnt++;
      prev_write = (wr_we != 4'h0) || (ev_we != 4'h0);
   end

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_ref(input logic [7:0] b);
      for (int i = 0; i < 64; i++) ref_mem[i] = {4{b}};
   endtask

   task automatic drive_row(input int npix);
      href = 1'b1;
      if (npix == 0) begin
         repeat (2) step();
      end else begin
         pix_valid = 1'b1;
         repeat (npix) step();
         pix_valid = 1'b0;
      end
      href = 1'b0;
      repeat (3) step();
   endtask

   task automatic run_frame(input int nwin, input int len, input int short_len,
                            input logic [7:0] p, input logic cap);
      pix_data = p;
      capture  = cap;
      vsync    = 1'b1;
      repeat (4) step();
      vsync = 1'b0;
      repeat (3) step();
      for (int r = 0; r < WIN_Y0 + nwin; r++) begin
         if (r < WIN_Y0) drive_row(0);
         else if (r == WIN_Y0 && short_len > 0) drive_row(short_len);
         else drive_row(len);
      end
      vsync = 1'b1;
      repeat (6) step();
   endtask

   task automatic test_reset();
      reset = 1'b1; vsync = 1'b1; href = 1'b0; pix_valid = 1'b0;
      pix_data = 8'h00; threshold = 8'h00; capture = 1'b0;
      repeat (4) step();
      n_tests++;
      if ({new_frame, read_new_line, write_new_line, line_short} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {new_frame, read_new_line, write_new_line, line_short});
      end
      n_tests++;
      if ({wr_we, ev_we, rd_addr, ev_count} !== 42'h0) begin
         n_fail++; $display("FAIL reset_ports: got we=%h/%h rd=%0d cnt=%0d expected all 0", wr_we, ev_we, rd_addr, ev_count);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_on_events();
      int s_wr, s_ev, s_wb, s_eb, s_web, s_wnl, s_wnlb, s_rnl, s_nf;
      set_ref(8'h80); threshold = 8'h10;
      exp_wr = 32'h91919191; exp_ev = 32'h55555555;
      s_wr = wr_cnt; s_ev = ev_cnt; s_wb = wr_bad; s_eb = ev_bad; s_web = we_bad;
      s_wnl = wnl_cnt; s_wnlb = wnl_bad; s_rnl = rnl_cnt; s_nf = nf_cnt;
      run_frame(16, 320, 0, 8'h91, 1'b0);
      n_tests++; if (wr_cnt - s_wr !== 512) begin n_fail++; $display("FAIL on_wr_count: got %0d expected 512", wr_cnt - s_wr); end
      n_tests++; if (ev_cnt - s_ev !== 128) begin n_fail++; $display("FAIL on_ev_count_writes: got %0d expected 128", ev_cnt - s_ev); end
      n_tests++; if (wr_bad - s_wb !== 0) begin n_fail++; $display("FAIL on_wr_data: %0d words differ from %h, last %h", wr_bad - s_wb, exp_wr, last_wr); end
      n_tests++; if (ev_bad - s_eb !== 0) begin n_fail++; $display("FAIL on_ev_data: %0d words differ from %h, last %h", ev_bad - s_eb, exp_ev, last_ev); end
      n_tests++; if (we_bad - s_web !== 0) begin n_fail++; $display("FAIL on_we_mask: got %0d partial enables expected 0", we_bad - s_web); end
      n_tests++; if (wnl_cnt - s_wnl !== 16) begin n_fail++; $display("FAIL on_write_new_line: got %0d expected 16", wnl_cnt - s_wnl); end
      n_tests++; if (wnl_bad - s_wnlb !== 0) begin n_fail++; $display("FAIL on_wnl_timing: got %0d misplaced expected 0", wnl_bad - s_wnlb); end
      n_tests++; if (rnl_cnt - s_rnl !== 17) begin n_fail++; $display("FAIL on_read_new_line: got %0d expected 17", rnl_cnt - s_rnl); end
      n_tests++; if (nf_cnt - s_nf !== 1) begin n_fail++; $display("FAIL on_new_frame: got %0d expected 1", nf_cnt - s_nf); end
      n_tests++; if (ev_count !== 16'd2048) begin n_fail++; $display("FAIL on_ev_count: got %0d expected 2048", ev_count); end
      n_tests++; if (last_wr_addr !== 17'd31) begin n_fail++; $display("FAIL on_last_wr_addr: got %0d expected 31", last_wr_addr); end
      n_tests++; if (last_ev_addr !== 17'd7) begin n_fail++; $display("FAIL on_last_ev_addr: got %0d expected 7", last_ev_addr); end
   endtask

   task automatic test_equal_threshold();
      int s_wr, s_wb, s_eb;
      set_ref(8'h80); threshold = 8'h10;
      exp_wr = 32'h80808080; exp_ev = 32'h00000000;
      s_wr = wr_cnt; s_wb = wr_bad; s_eb = ev_bad;
      run_frame(2, 320, 0, 8'h90, 1'b0);
      n_tests++; if (wr_cnt - s_wr !== 64) begin n_fail++; $display("FAIL eq_wr_count: got %0d expected 64", wr_cnt - s_wr); end
      n_tests++; if (wr_bad - s_wb !== 0) begin n_fail++; $display("FAIL eq_wr_data: last %h expected %h", last_wr, exp_wr); end
      n_tests++; if (ev_bad - s_eb !== 0) begin n_fail++; $display("FAIL eq_ev_data: last %h expected %h", last_ev, exp_ev); end
      n_tests++; if (ev_count !== 16'd0) begin n_fail++; $display("FAIL eq_ev_count: got %0d expected 0", ev_count); end
   endtask

   task automatic test_off_events();
      int s_wb, s_eb;
      set_ref(8'hF0); threshold = 8'h05;
      exp_wr = 32'h00000000; exp_ev = 32'hAAAAAAAA;
      s_wb = wr_bad; s_eb = ev_bad;
      run_frame(2, 320, 0, 8'h00, 1'b0);
      n_tests++; if (ev_bad - s_eb !== 0) begin n_fail++; $display("FAIL off_ev_data: last %h expected %h", last_ev, exp_ev); end
      n_tests++; if (wr_bad - s_wb !== 0) begin n_fail++; $display("FAIL off_wr_data: last %h expected %h", last_wr, exp_wr); end
      n_tests++; if (ev_count !== 16'd256) begin n_fail++; $display("FAIL off_ev_count: got %0d expected 256", ev_count); end
   endtask

   task automatic test_capture();
      int s_wr, s_wb, s_eb;
      set_ref(8'h80); threshold = 8'h10;
      exp_wr = 32'h91919191; exp_ev = 32'h00000000;
      s_wr = wr_cnt; s_wb = wr_bad; s_eb = ev_bad;
      run_frame(2, 320, 0, 8'h91, 1'b1);
      capture = 1'b0;
      n_tests++; if (wr_cnt - s_wr !== 64) begin n_fail++; $display("FAIL cap_wr_count: got %0d expected 64", wr_cnt - s_wr); end
      n_tests++; if (wr_bad - s_wb !== 0) begin n_fail++; $display("FAIL cap_wr_data: last %h expected %h", last_wr, exp_wr); end
      n_tests++; if (ev_bad - s_eb !== 0) begin n_fail++; $display("FAIL cap_ev_data: last %h expected %h", last_ev, exp_ev); end
      n_tests++; if (ev_count !== 16'd0) begin n_fail++; $display("FAIL cap_ev_count: got %0d expected 0", ev_count); end
   endtask

   task automatic test_full_frame();
      int s_wr, s_ev, s_wnl, s_rnl;
      set_ref(8'h80); threshold = 8'h10;
      exp_wr = 32'h80808080; exp_ev = 32'h00000000;
      s_wr = wr_cnt; s_ev = ev_cnt; s_wnl = wnl_cnt; s_rnl = rnl_cnt;
      run_frame(128, 224, 0, 8'h80, 1'b0);
      n_tests++; if (rnl_cnt - s_rnl !== 128) begin n_fail++; $display("FAIL full_read_new_line: got %0d expected 128", rnl_cnt - s_rnl); end
      n_tests++; if (wnl_cnt - s_wnl !== 128) begin n_fail++; $display("FAIL full_write_new_line: got %0d expected 128", wnl_cnt - s_wnl); end
      n_tests++; if (wr_cnt - s_wr !== 4096) begin n_fail++; $display("FAIL full_wr_count: got %0d expected 4096", wr_cnt - s_wr); end
      n_tests++; if (ev_cnt - s_ev !== 1024) begin n_fail++; $display("FAIL full_ev_writes: got %0d expected 1024", ev_cnt - s_ev); end
      n_tests++; if (line_short !== 1'b0) begin n_fail++; $display("FAIL full_line_short: got %b expected 0", line_short); end
   endtask

   task automatic test_short_line();
      int s_wr, s_ev, s_wnl;
      set_ref(8'h80); threshold = 8'h10;
      exp_wr = 32'h91919191; exp_ev = 32'h55555555;
      s_wr = wr_cnt; s_ev = ev_cnt; s_wnl = wnl_cnt;
      run_frame(1, 320, 150, 8'h91, 1'b0);
      n_tests++; if (wr_cnt - s_wr !== 14) begin n_fail++; $display("FAIL short_wr_count: got %0d expected 14", wr_cnt - s_wr); end
      n_tests++; if (ev_cnt - s_ev !== 4) begin n_fail++; $display("FAIL short_ev_writes: got %0d expected 4", ev_cnt - s_ev); end
      n_tests++; if (last_wr !== 32'h80809191 || last_wr_addr !== 17'd13) begin n_fail++; $display("FAIL short_ref_flush: got %h@%0d expected 80809191@13", last_wr, last_wr_addr); end
      n_tests++; if (last_ev !== 32'h00000555 || last_ev_addr !== 17'd3) begin n_fail++; $display("FAIL short_ev_flush: got %h@%0d expected 00000555@3", last_ev, last_ev_addr); end
      n_tests++; if (line_short !== 1'b1) begin n_fail++; $display("FAIL short_line_short: got %b expected 1", line_short); end
      n_tests++; if (wnl_cnt - s_wnl !== 1) begin n_fail++; $display("FAIL short_write_new_line: got %0d expected 1", wnl_cnt - s_wnl); end
      n_tests++; if (ev_count !== 16'd54) begin n_fail++; $display("FAIL short_ev_count: got %0d expected 54", ev_count); end
   endtask

   task automatic test_reset_midline();
      int s_wr, s_ev, s_wnl;
      set_ref(8'h80); threshold = 8'h10; pix_data = 8'h91;
      vsync = 1'b1; repeat (4) step();
      vsync = 1'b0; repeat (3) step();
      for (int r = 0; r < WIN_Y0; r++) drive_row(0);
      href = 1'b1; pix_valid = 1'b1;
      repeat (118) step();
      s_wr = wr_cnt; s_ev = ev_cnt; s_wnl = wnl_cnt;
      reset = 1'b1;
      step();
      n_tests++;
      if ({new_frame, read_new_line, write_new_line, line_short, wr_we, ev_we} !== 12'h000) begin
         n_fail++; $display("FAIL midreset_flags: got %h expected 000", {new_frame, read_new_line, write_new_line, line_short, wr_we, ev_we});
      end
      n_tests++;
      if ({rd_addr, wr_addr, ev_addr, wr_data, ev_data, ev_count} !== 131'h0) begin
         n_fail++; $display("FAIL midreset_buses: rd=%0d wa=%0d ea=%0d wd=%h ed=%h cnt=%0d expected all 0", rd_addr, wr_addr, ev_addr, wr_data, ev_data, ev_count);
      end
      repeat (2) step();
      reset = 1'b0;
      repeat (40) step();
      pix_valid = 1'b0; href = 1'b0;
      repeat (4) step();
      vsync = 1'b1;
      repeat (6) step();
      n_tests++; if (wr_cnt - s_wr !== 0 || ev_cnt - s_ev !== 0) begin n_fail++; $display("FAIL midreset_writes: got %0d/%0d expected 0/0", wr_cnt - s_wr, ev_cnt - s_ev); end
      n_tests++; if (wnl_cnt - s_wnl !== 0) begin n_fail++; $display("FAIL midreset_wnl: got %0d expected 0", wnl_cnt - s_wnl); end
      n_tests++; if (line_short !== 1'b0 || ev_count !== 16'd0) begin n_fail++; $display("FAIL midreset_state: line_short=%b ev_count=%0d expected 0/0", line_short, ev_count); end
   endtask

   initial begin
      test_reset();
      test_on_events();
      test_equal_threshold();
      test_off_events();
      test_capture();
      test_full_frame();
      test_short_line();
      test_reset_midline();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
